// File: rtl/ysyx_25040101_ctrl_fsm.sv
// ysyx_25040101_ctrl_fsm
// Multi-cycle RV32I control sequencer. Takes one instruction per IFU handshake,
// decodes it into a registered control bundle, then walks it through
// EXE -> (MREQ -> MWAIT) -> WB. Ebreak, illegal encodings and LSU faults or
// timeouts park the sequencer in a sticky HALT state that only reset leaves.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   ifu_valid_i / ifu_ready_o     instruction handshake, inst_i the word
//   lsu_req_valid_o / _ready_i    LSU request handshake, lsu_req_we_o = store
//   lsu_resp_valid_i / _err_i     LSU completion and bus error
//   alu_ctrl_o .. is_mret_o       registered decode bundle for the datapath
//   rd_wen_o, pc_wen_o            one-cycle write strobes in WB
//   halted_o, halt_cause_o        sticky halt flag and cause
module ysyx_25040101_ctrl_fsm #(
  parameter bit EN_CSR      = 1'b1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ifu_valid_i,
  output logic        ifu_ready_o,
  input  logic [31:0] inst_i,
  output logic        lsu_req_valid_o,
  input  logic        lsu_req_ready_i,
  output logic        lsu_req_we_o,
  input  logic        lsu_resp_valid_i,
  input  logic        lsu_resp_err_i,
  output logic [7:0]  alu_ctrl_o,
  output logic [1:0]  srca_ctrl_o,
  output logic [2:0]  srcb_ctrl_o,
  output logic [5:0]  imm_type_o,
  output logic        pc_ctrl_o,
  output logic        pc_srca_ctrl_o,
  output logic        pc_srcb_ctrl_o,
  output logic [3:0]  mem_op_o,
  output logic        is_branch_o,
  output logic [2:0]  br_cond_o,
  output logic [1:0]  slt_ctrl_o,
  output logic [1:0]  csr_op_o,
  output logic        csr_imm_o,
  output logic        is_ecall_o,
  output logic        is_mret_o,
  output logic        rd_wen_o,
  output logic        pc_wen_o,
  output logic        halted_o,
  output logic [1:0]  halt_cause_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DEC   = 3'd1;
  localparam logic [2:0] S_EXE   = 3'd2;
  localparam logic [2:0] S_MREQ  = 3'd3;
  localparam logic [2:0] S_MWAIT = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  // One-hot ALU op codes: bit0 add .. bit7 xor
  localparam logic [7:0] ALU_ADD = 8'h01;
  localparam logic [7:0] ALU_SUB = 8'h02;
  localparam logic [7:0] ALU_SRA = 8'h04;
  localparam logic [7:0] ALU_SRL = 8'h08;
  localparam logic [7:0] ALU_SLL = 8'h10;
  localparam logic [7:0] ALU_AND = 8'h20;
  localparam logic [7:0] ALU_OR  = 8'h40;
  localparam logic [7:0] ALU_XOR = 8'h80;

  localparam logic [5:0] IMM_I = 6'b100000;
  localparam logic [5:0] IMM_S = 6'b010000;
  localparam logic [5:0] IMM_B = 6'b001000;
  localparam logic [5:0] IMM_U = 6'b000100;
  localparam logic [5:0] IMM_J = 6'b000010;
  localparam logic [5:0] IMM_SH = 6'b000001;

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // cnt_q holds MWAIT cycles already spent, so the current cycle is number
  // cnt_q+1; the timeout fires on the MEM_TIMEOUT-th cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef struct packed {
    logic [7:0] alu;
    logic [1:0] srca;
    logic [2:0] srcb;
    logic [5:0] imm;
    logic       pc_ctrl;
    logic       pc_srca;
    logic       pc_srcb;
    logic [3:0] mem_op;
    logic       is_mem;
    logic       is_branch;
    logic [2:0] br_cond;
    logic [1:0] slt;
    logic [1:0] csr_op;
    logic       csr_imm;
    logic       is_ecall;
    logic       is_mret;
    logic       rd_wen;
  } bundle_t;

  logic [2:0]    state_q, state_d;
  logic [31:0]   inst_q, inst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;
  bundle_t       bundle_q, bundle_d, dec_b;
  logic          illegal, ebreak, wr;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       f7_ok;
  assign opcode = inst_q[6:0];
  assign f3     = inst_q[14:12];
  assign f7     = inst_q[31:25];
  assign f7_ok  = (f7 == 7'h00) || (f7 == 7'h20);

  // Combinational decode of the latched word
  always_comb begin
    dec_b   = '0;
    illegal = 1'b0;
    ebreak  = 1'b0;
    wr      = 1'b0;
    case (opcode)
      7'b0110011: begin // OP
        wr = 1'b1;
        case (f3)
          3'b000: begin dec_b.alu = f7[5] ? ALU_SUB : ALU_ADD; illegal = !f7_ok; end
          3'b001: begin dec_b.alu = ALU_SLL; dec_b.srcb = 3'b100; illegal = (f7 != 7'h00); end
          3'b010: begin dec_b.alu = ALU_SUB; dec_b.slt = 2'b01; illegal = (f7 != 7'h00); end
          3'b011: begin dec_b.alu = ALU_SUB; dec_b.slt = 2'b10; illegal = (f7 != 7'h00); end
          3'b100: begin dec_b.alu = ALU_XOR; illegal = (f7 != 7'h00); end
          3'b101: begin
            dec_b.alu  = f7[5] ? ALU_SRA : ALU_SRL;
            dec_b.srcb = 3'b100;
            illegal    = !f7_ok;
          end
          3'b110: begin dec_b.alu = ALU_OR;  illegal = (f7 != 7'h00); end
          default: begin dec_b.alu = ALU_AND; illegal = (f7 != 7'h00); end
        endcase
      end
      7'b0010011: begin // OP-IMM
        wr         = 1'b1;
        dec_b.srcb = 3'b001;
        dec_b.imm  = IMM_I;
        case (f3)
          3'b000: dec_b.alu = ALU_ADD;
          3'b010: begin dec_b.alu = ALU_SUB; dec_b.slt = 2'b01; end
          3'b011: begin dec_b.alu = ALU_SUB; dec_b.slt = 2'b10; end
          3'b100: dec_b.alu = ALU_XOR;
          3'b110: dec_b.alu = ALU_OR;
          3'b111: dec_b.alu = ALU_AND;
          3'b001: begin dec_b.alu = ALU_SLL; dec_b.imm = IMM_SH; illegal = (f7 != 7'h00); end
          default: begin
            // inst[30] picks arithmetic shift; the other funct7 bits must be clear
            dec_b.alu = inst_q[30] ? ALU_SRA : ALU_SRL;
            dec_b.imm = IMM_SH;
            illegal   = inst_q[31] || (inst_q[29:25] != 5'd0);
          end
        endcase
      end
      7'b0000011: begin // LOAD
        wr           = 1'b1;
        dec_b.alu    = ALU_ADD;
        dec_b.srcb   = 3'b001;
        dec_b.imm    = IMM_I;
        dec_b.is_mem = 1'b1;
        case (f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101:
            dec_b.mem_op = {1'b0, f3[1:0], f3[2]};
          default: illegal = 1'b1;
        endcase
      end
      7'b0100011: begin // STORE
        dec_b.alu    = ALU_ADD;
        dec_b.srcb   = 3'b001;
        dec_b.imm    = IMM_S;
        dec_b.is_mem = 1'b1;
        dec_b.mem_op = {1'b1, f3[1:0], 1'b0};
        illegal      = (f3[2] || f3 == 3'b011);
      end
      7'b1100011: begin // BRANCH
        dec_b.is_branch = 1'b1;
        dec_b.br_cond   = f3;
        dec_b.alu       = ALU_SUB;
        dec_b.imm       = IMM_B;
        dec_b.slt       = f3[2] ? (f3[1] ? 2'b10 : 2'b01) : 2'b00;
        illegal         = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b0110111: begin // LUI: 0 + imm
        wr = 1'b1; dec_b.alu = ALU_ADD; dec_b.srca = 2'b10; dec_b.srcb = 3'b001; dec_b.imm = IMM_U;
      end
      7'b0010111: begin // AUIPC: pc + imm
        wr = 1'b1; dec_b.alu = ALU_ADD; dec_b.srca = 2'b01; dec_b.srcb = 3'b001; dec_b.imm = IMM_U;
      end
      7'b1101111: begin // JAL: rd = pc + 4, pc += imm
        wr = 1'b1; dec_b.alu = ALU_ADD; dec_b.srca = 2'b01; dec_b.srcb = 3'b010;
        dec_b.imm = IMM_J; dec_b.pc_srcb = 1'b1;
      end
      7'b1100111: begin // JALR: rd = pc + 4, pc = (rs1 + imm) & ~1
        wr = 1'b1; dec_b.alu = ALU_ADD; dec_b.srca = 2'b01; dec_b.srcb = 3'b010;
        dec_b.imm = IMM_I; dec_b.pc_ctrl = 1'b1; dec_b.pc_srca = 1'b1; dec_b.pc_srcb = 1'b1;
        illegal = (f3 != 3'b000);
      end
      7'b0001111: illegal = (f3 != 3'b000); // FENCE: empty bundle
      7'b1110011: begin // SYSTEM
        if (f3 == 3'b000) begin
          if (inst_q[19:15] != 5'd0 || inst_q[11:7] != 5'd0) begin
            illegal = 1'b1;
          end else begin
            case (inst_q[31:20])
              12'h000: begin dec_b.is_ecall = EN_CSR; illegal = !EN_CSR; end
              12'h001: ebreak = 1'b1;
              12'h302: begin dec_b.is_mret = EN_CSR; illegal = !EN_CSR; end
              default: illegal = 1'b1;
            endcase
          end
        end else if (f3 == 3'b100 || !EN_CSR) begin
          illegal = 1'b1;
        end else begin
          wr            = 1'b1;
          dec_b.csr_op  = f3[1:0];
          dec_b.csr_imm = f3[2];
          dec_b.imm     = IMM_I;
        end
      end
      default: illegal = 1'b1;
    endcase
    dec_b.rd_wen = wr && (inst_q[11:7] != 5'd0);
  end

  // Sequencer
  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    bundle_d = bundle_q;
    case (state_q)
      S_IDLE: begin
        if (ifu_valid_i) begin
          inst_d  = inst_i;
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        // Halting encodings leave an empty bundle behind
        bundle_d = (illegal || ebreak) ? '0 : dec_b;
        if (illegal) begin
          state_d = S_HALT;
          cause_d = 2'b10;
        end else if (ebreak) begin
          state_d = S_HALT;
          cause_d = 2'b01;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE:   state_d = bundle_q.is_mem ? S_MREQ : S_WB;
      S_MREQ: begin
        if (lsu_req_ready_i) begin
          state_d = S_MWAIT;
          cnt_d   = '0;
        end
      end
      S_MWAIT: begin
        // A response, good or bad, takes priority over the timeout
        if (lsu_resp_valid_i) begin
          if (lsu_resp_err_i) begin
            state_d = S_HALT;
            cause_d = 2'b11;
          end else begin
            state_d = S_WB;
          end
        end else if ((MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_HALT;
          cause_d = 2'b11;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB:    state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      inst_q   <= '0;
      cnt_q    <= '0;
      cause_q  <= 2'b00;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      bundle_q <= bundle_d;
    end
  end

  // Outputs are forced low while reset is asserted so nothing leaks out of
  // the IDLE decode during the reset window.
  logic    run;
  bundle_t bo;
  assign run = !rst_i;
  assign bo  = run ? bundle_q : '0;

  assign ifu_ready_o     = run && (state_q == S_IDLE);
  assign lsu_req_valid_o = run && (state_q == S_MREQ);
  assign lsu_req_we_o    = bo.mem_op[3];
  assign alu_ctrl_o      = bo.alu;
  assign srca_ctrl_o     = bo.srca;
  assign srcb_ctrl_o     = bo.srcb;
  assign imm_type_o      = bo.imm;
  assign pc_ctrl_o       = bo.pc_ctrl;
  assign pc_srca_ctrl_o  = bo.pc_srca;
  assign pc_srcb_ctrl_o  = bo.pc_srcb;
  assign mem_op_o        = bo.mem_op;
  assign is_branch_o     = bo.is_branch;
  assign br_cond_o       = bo.br_cond;
  assign slt_ctrl_o      = bo.slt;
  assign csr_op_o        = bo.csr_op;
  assign csr_imm_o       = bo.csr_imm;
  assign is_ecall_o      = bo.is_ecall;
  assign is_mret_o       = bo.is_mret;
  assign rd_wen_o        = run && (state_q == S_WB) && bundle_q.rd_wen;
  assign pc_wen_o        = run && (state_q == S_WB);
  assign halted_o        = run && (state_q == S_HALT);
  assign halt_cause_o    = halted_o ? cause_q : 2'b00;

endmodule
